// File: rtl/ama_riscv_bp_spec.sv
// Speculative-history branch predictor: PHT of saturating counters indexed by
// bimodal/gshare/gselect, with a checkpoint FIFO for up to INFLIGHT unresolved branches.
module ama_riscv_bp_spec #(
  parameter int unsigned PC_W     = 5,
  parameter int unsigned GHR_W    = 5,
  parameter int unsigned CNT_W    = 2,
  parameter int unsigned INFLIGHT = 4,
  parameter int unsigned MODE     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pred_req,
  input  logic [31:0] pred_pc,
  output logic        pred_ready,
  output logic        pred_taken,
  input  logic        res_valid,
  input  logic        res_taken,
  output logic        res_mispred,
  input  logic        flush,
  output logic [31:0] cnt_br,
  output logic [31:0] cnt_mispred
);

  localparam int unsigned GMAX    = (PC_W > GHR_W) ? PC_W : GHR_W;
  localparam int unsigned IDX_W   = (MODE == 0) ? PC_W : (MODE == 1) ? GMAX : PC_W + GHR_W;
  localparam int unsigned PHT_N   = 1 << IDX_W;
  localparam int unsigned GSH     = (PC_W > GHR_W) ? PC_W - GHR_W : 0;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
  localparam int unsigned THR     = 1 << (CNT_W - 1);
  localparam int unsigned AW      = $clog2(INFLIGHT);
  localparam int unsigned PTR_W   = AW + 1;

  logic [CNT_W-1:0]    pht [PHT_N];
  logic [IDX_W-1:0]    fifo_idx [INFLIGHT];
  logic [INFLIGHT-1:0] fifo_pred;
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;
  logic [GHR_W-1:0]    spec_ghr, arch_ghr;

  logic [PC_W-1:0]  pc_bits;
  logic [IDX_W-1:0] idx;
  logic             unused_pc_bits;
  logic             empty, full, res_fire, kill, push;
  logic [IDX_W-1:0] head_idx;
  logic             head_pred;
  logic [GHR_W-1:0] arch_ghr_nxt_c;

  function automatic logic [GHR_W-1:0] shift_in(input logic [GHR_W-1:0] g, input logic b);
    return (g << 1) | GHR_W'(b);
  endfunction

  function automatic logic [CNT_W-1:0] cnt_upd(input logic [CNT_W-1:0] c, input logic t);
    logic [CNT_W-1:0] r;
    r = c;
    if (CNT_W == 1)                          r = CNT_W'(t);
    else if (t && c != CNT_W'(CNT_MAX))      r = c + CNT_W'(1);
    else if (!t && c != '0)                  r = c - CNT_W'(1);
    return r;
  endfunction

  assign pc_bits        = pred_pc[PC_W+1:2];
  assign unused_pc_bits = ^{pred_pc[31:PC_W+2], pred_pc[1:0]};

  // PHT index selection by MODE, always from the speculative history
  if (MODE == 0) begin : g_bimodal
    assign idx = pc_bits;
  end else if (MODE == 1) begin : g_gshare
    assign idx = IDX_W'(pc_bits) ^ (IDX_W'(spec_ghr) << GSH);
  end else begin : g_gselect
    assign idx = {pc_bits, spec_ghr};
  end

  assign pred_taken  = pht[idx] >= CNT_W'(THR);
  assign empty       = (rd_ptr == wr_ptr);
  assign full        = (rd_ptr[AW] != wr_ptr[AW]) && (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);
  assign pred_ready  = !full;
  assign head_idx    = fifo_idx[rd_ptr[AW-1:0]];
  assign head_pred   = fifo_pred[rd_ptr[AW-1:0]];
  assign res_fire    = res_valid && !empty;
  assign res_mispred = res_fire && (res_taken != head_pred);
  assign kill        = res_mispred || flush;
  assign push        = pred_req && !full && !kill;

  assign arch_ghr_nxt_c = res_fire ? shift_in(arch_ghr, res_taken) : arch_ghr;

  // Counter table; no read bypass, so a same-cycle predict sees the old counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < PHT_N; i++) pht[i] <= CNT_W'(THR);
    end else if (res_fire) begin
      pht[head_idx] <= cnt_upd(pht[head_idx], res_taken);
    end
  end

  // Checkpoint payload storage; validity is tracked by the pointers alone
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx[wr_ptr[AW-1:0]]  <= idx;
      fifo_pred[wr_ptr[AW-1:0]] <= pred_taken;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      spec_ghr    <= '0;
      arch_ghr    <= '0;
      cnt_br      <= '0;
      cnt_mispred <= '0;
    end else begin
      arch_ghr <= arch_ghr_nxt_c;
      if (res_fire)    cnt_br      <= cnt_br + 32'd1;
      if (res_mispred) cnt_mispred <= cnt_mispred + 32'd1;
      // Mispredict or flush discards all younger checkpoints and repairs history
      if (kill) begin
        rd_ptr   <= wr_ptr;
        spec_ghr <= arch_ghr_nxt_c;
      end else begin
        if (res_fire) rd_ptr <= rd_ptr + PTR_W'(1);
        if (push) begin
          wr_ptr   <= wr_ptr + PTR_W'(1);
          spec_ghr <= shift_in(spec_ghr, pred_taken);
        end
      end
    end
  end

  res_on_empty: assert property (@(posedge clk) disable iff (!rst_n) !(res_valid && empty));

endmodule

// File: tb/tb_ama_riscv_bp_spec.sv
// Directed table-driven bench for ama_riscv_bp_spec; three instances cover
// bimodal, gshare and 1-bit-counter gselect configurations.
module tb_ama_riscv_bp_spec;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       req, res, rt, fl;
  logic [2:0][31:0] pc;
  logic [2:0]       rdy, tkn, mp;
  logic [2:0][31:0] cbr, cmp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ama_riscv_bp_spec #(.MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .pred_req(req[0]), .pred_pc(pc[0]), .pred_ready(rdy[0]),
    .pred_taken(tkn[0]), .res_valid(res[0]), .res_taken(rt[0]), .res_mispred(mp[0]),
    .flush(fl[0]), .cnt_br(cbr[0]), .cnt_mispred(cmp[0]));

  ama_riscv_bp_spec #(.MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .pred_req(req[1]), .pred_pc(pc[1]), .pred_ready(rdy[1]),
    .pred_taken(tkn[1]), .res_valid(res[1]), .res_taken(rt[1]), .res_mispred(mp[1]),
    .flush(fl[1]), .cnt_br(cbr[1]), .cnt_mispred(cmp[1]));

  ama_riscv_bp_spec #(.CNT_W(1), .GHR_W(1), .MODE(2)) u2 (
    .clk(clk), .rst_n(rst_n), .pred_req(req[2]), .pred_pc(pc[2]), .pred_ready(rdy[2]),
    .pred_taken(tkn[2]), .res_valid(res[2]), .res_taken(rt[2]), .res_mispred(mp[2]),
    .flush(fl[2]), .cnt_br(cbr[2]), .cnt_mispred(cmp[2]));

  typedef struct {
    int          sel;
    logic        req;
    logic [31:0] pc;
    logic        res;
    logic        rt;
    logic        fl;
    int          er;   // expected pred_ready, -1 = skip
    int          et;   // expected pred_taken, -1 = skip
    int          em;   // expected res_mispred
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(int sel, logic rq, logic [31:0] p, logic rv, logic t, logic f,
                              int er, int et, int em);
    vec_t v;
    v.sel = sel; v.req = rq; v.pc = p; v.res = rv; v.rt = t; v.fl = f;
    v.er = er; v.et = et; v.em = em;
    return v;
  endfunction

  task automatic add(int sel, logic rq, logic [31:0] p, logic rv, logic t, logic f,
                     int er, int et, int em);
    tab.push_back(mk(sel, rq, p, rv, t, f, er, et, em));
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    req = '0; res = '0; rt = '0; fl = '0; pc = '0;
  endtask

  task automatic drive(vec_t v);
    idle();
    req[v.sel] = v.req; pc[v.sel] = v.pc; res[v.sel] = v.res;
    rt[v.sel] = v.rt; fl[v.sel] = v.fl;
  endtask

  task automatic apply(vec_t v, string tag);
    @(posedge clk); #1;
    drive(v);
    @(negedge clk);
    if (v.er >= 0) chk({tag, " ready"}, 32'(rdy[v.sel]), 32'(v.er));
    if (v.et >= 0) chk({tag, " taken"}, 32'(tkn[v.sel]), 32'(v.et));
    chk({tag, " mispred"}, 32'(mp[v.sel]), 32'(v.em));
  endtask

  task automatic chk_cnt(int s, int br, int mpc, string tag);
    chk({tag, " cnt_br"}, cbr[s], 32'(br));
    chk({tag, " cnt_mispred"}, cmp[s], 32'(mpc));
  endtask

  initial begin
    rst_n = 1'b0;
    idle();

    // Bimodal: warm-up, saturation at 3, walk down to not-taken
    for (int k = 0; k < 3; k++) add(0, 1, 32'h40, 0, 0, 0, 1, 1, 0);
    for (int k = 0; k < 3; k++) add(0, 0, 32'h40, 1, 1, 0, 1, -1, 0);
    add(0, 1, 32'h40, 0, 0, 0, 1, 1, 0);
    add(0, 0, 32'h40, 1, 0, 0, 1, -1, 1);
    add(0, 1, 32'h40, 0, 0, 0, 1, 1, 0);
    add(0, 0, 32'h40, 1, 0, 0, 1, -1, 1);
    add(0, 1, 32'h40, 0, 0, 0, 1, 0, 0);
    add(0, 0, 32'h40, 1, 0, 0, 1, -1, 0);
    add(0, 1, 32'h40, 0, 0, 0, 1, 0, 0);
    add(0, 0, 32'h40, 1, 1, 0, 1, -1, 1);
    // Full FIFO: no same-cycle bypass for a resolve
    for (int k = 0; k < 4; k++) add(0, 1, 32'h0, 0, 0, 0, 1, 1, 0);
    add(0, 1, 32'h0, 1, 1, 0, 0, 1, 0);
    add(0, 1, 32'h0, 0, 0, 0, 1, 1, 0);
    add(0, 0, 32'h0, 1, 1, 0, 0, -1, 0);
    add(0, 0, 32'h0, 1, 1, 0, 1, -1, 0);
    // Predict + flush with 2 in flight: nothing pushed, FIFO emptied
    add(0, 1, 32'h0, 0, 0, 1, 1, 1, 0);
    for (int k = 0; k < 4; k++) add(0, 1, 32'h0, 0, 0, 0, 1, 1, 0);
    add(0, 1, 32'h0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 32'h0, 1, 1, 0, 0, -1, 0);
    for (int k = 0; k < 3; k++) add(0, 0, 32'h0, 1, 1, 0, 1, -1, 0);

    // Gshare: speculative history and its repair
    for (int k = 0; k < 3; k++) add(1, 1, 32'h0, 0, 0, 0, 1, 1, 0);
    add(1, 0, 32'h0, 1, 0, 0, 1, -1, 1);
    add(1, 1, 32'h0, 0, 0, 0, 1, 0, 0);
    add(1, 0, 32'h0, 1, 0, 0, 1, -1, 0);
    add(1, 1, 32'h4, 0, 0, 0, 1, 1, 0);
    add(1, 1, 32'h4, 0, 0, 0, 1, 0, 0);
    add(1, 1, 32'h4, 0, 0, 1, 1, 1, 0);
    add(1, 1, 32'h0, 0, 0, 0, 1, 0, 0);
    add(1, 0, 32'h0, 1, 1, 0, 1, -1, 1);
    add(1, 1, 32'h4, 0, 0, 0, 1, 0, 0);
    add(1, 0, 32'h0, 1, 1, 1, 1, -1, 1);

    // Gselect, 1-bit counters, 1-bit history: alternating pattern learned
    for (int k = 1; k <= 8; k++) begin
      add(2, 1, 32'h0, 0, 0, 0, 1, (k <= 3) ? 1 : (k % 2), 0);
      add(2, 0, 32'h0, 1, 1'(k % 2), 0, 1, -1, (k == 2) ? 1 : 0);
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("reset%0d ready", s), 32'(rdy[s]), 32'd1);
      chk($sformatf("reset%0d mispred", s), 32'(mp[s]), 32'd0);
      chk_cnt(s, 0, 0, $sformatf("reset%0d", s));
    end
    rst_n = 1'b1;

    for (int i = 0; i < tab.size(); i++) apply(tab[i], $sformatf("row%0d", i));
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk_cnt(0, 14, 3, "bimodal");
    chk_cnt(1, 4, 3, "gshare");
    chk_cnt(2, 8, 1, "gselect");

    // Asynchronous reset in the middle of a burst
    for (int k = 0; k < 4; k++) apply(mk(0, 1, 32'h40, 0, 0, 0, 1, 0, 0), $sformatf("burst%0d", k));
    apply(mk(0, 0, 32'h40, 1, 1, 0, 0, -1, 1), "burst_res");
    #2 rst_n = 1'b0;
    #1;
    chk("async ready", 32'(rdy[0]), 32'd1);
    chk("async mispred", 32'(mp[0]), 32'd0);
    chk("async pht thr", 32'(tkn[0]), 32'd1);
    chk_cnt(0, 0, 0, "async");
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(0, 1, 32'h40, 0, 0, 0, 1, 1, 0), "post_rst pred");
    apply(mk(0, 0, 32'h40, 1, 1, 0, 1, -1, 0), "post_rst res");
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk_cnt(0, 1, 0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
